// File: rtl/mem_stage_pkg.sv
// Shared pipeline package for the memory stage: widths, timeout default,
// FSM state encoding and a small sizing helper.
package mem_stage_pkg;

    localparam int MEM_DATA_WIDTH = 16;
    localparam int MEM_ADDR_WIDTH = 8;
    localparam int MEM_REG_WIDTH  = 4;
    localparam int MEM_TIMEOUT    = 15;

    // IDLE: ready to issue a request; WAIT: a request is outstanding.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    // Number of bits needed to hold a count running from 0 up to max_count.
    function automatic int cnt_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/mem_stage_mem_wb_reg.sv
// MEM/WB pipeline register. When load_i is low it inserts a bubble by
// clearing the write-back controls while the data fields keep their value.
module mem_wb_reg
    import mem_stage_pkg::*;
#(
    parameter int DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int REG_WIDTH  = MEM_REG_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    input  logic [REG_WIDTH-1:0]  write_reg_i,
    input  logic                  reg_write_i,
    input  logic                  mem_to_reg_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic [DATA_WIDTH-1:0] wb_result_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic [REG_WIDTH-1:0]  write_reg_o,
    output logic                  reg_write_o,
    output logic                  mem_to_reg_o
);

    logic [DATA_WIDTH-1:0] wb_result_q, wb_result_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
    logic [REG_WIDTH-1:0]  write_reg_q, write_reg_d;
    logic                  reg_write_q, reg_write_d;
    logic                  mem_to_reg_q, mem_to_reg_d;

    // Next MEM/WB contents: capture the instruction, or hold data and clear controls.
    always_comb begin
        wb_result_d  = wb_result_q;
        mem_data_d   = mem_data_q;
        write_reg_d  = write_reg_q;
        reg_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        if (load_i) begin
            wb_result_d  = alu_result_i;
            write_reg_d  = write_reg_i;
            reg_write_d  = reg_write_i;
            mem_to_reg_d = mem_to_reg_i;
            if (mem_to_reg_i) begin
                mem_data_d = rdata_i;
            end
        end
    end

    // MEM/WB register bank, cleared asynchronously by the active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_result_q  <= '0;
            mem_data_q   <= '0;
            write_reg_q  <= '0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else begin
            wb_result_q  <= wb_result_d;
            mem_data_q   <= mem_data_d;
            write_reg_q  <= write_reg_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
        end
    end

    assign wb_result_o  = wb_result_q;
    assign mem_data_o   = mem_data_q;
    assign write_reg_o  = write_reg_q;
    assign reg_write_o  = reg_write_q;
    assign mem_to_reg_o = mem_to_reg_q;

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: drives the data-memory handshake, stalls the pipe
// while an access is outstanding, aborts with a sticky error on timeout
// and feeds the MEM/WB register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int REG_WIDTH  = MEM_REG_WIDTH,
    parameter int TIMEOUT    = MEM_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ALUResultM_i,
    input  logic [DATA_WIDTH-1:0] WriteDataM_i,
    input  logic [REG_WIDTH-1:0]  WriteRegM_i,
    input  logic                  ValidM_i,
    input  logic                  RegWriteM_i,
    input  logic                  MemToRegM_i,
    input  logic                  MemWriteM_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ready_i,
    output logic [DATA_WIDTH-1:0] WBResultW_o,
    output logic [DATA_WIDTH-1:0] memData_r_o,
    output logic [REG_WIDTH-1:0]  WriteRegW_o,
    output logic                  RegWriteW_o,
    output logic                  MemToRegW_o,
    output logic                  StallM_o,
    output logic                  err_o
);

    localparam int CNT_W = cnt_width(TIMEOUT);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic mem_op;
    logic is_load;
    logic timed_out;
    logic mem_req;
    logic mem_done;
    logic stall;
    logic wb_load;

    // Decode the EX/MEM controls; load+store together counts as a store.
    always_comb begin
        mem_op  = ValidM_i & (MemToRegM_i | MemWriteM_i);
        is_load = MemToRegM_i & ~MemWriteM_i;
    end

    // State, wait counter and sticky error flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next state: wait for ready after an unanswered request, give up at TIMEOUT.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_op && !mem_ready_i) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                if (timed_out) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (mem_ready_i) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs: request, stall and MEM/WB load enable; all quiet in reset.
    always_comb begin
        timed_out = 1'b0;
        mem_req   = 1'b0;
        case (state_q)
            ST_IDLE: mem_req = mem_op;
            ST_WAIT: begin
                timed_out = (cnt_q == CNT_W'(TIMEOUT));
                mem_req   = ~timed_out;
            end
            default: mem_req = 1'b0;
        endcase
        mem_req  = mem_req & rst;
        mem_done = mem_req & mem_ready_i;
        stall    = mem_req & ~mem_ready_i;
        wb_load  = rst & ValidM_i & ~stall & (~mem_op | mem_done);
    end

    assign mem_req_o   = mem_req;
    assign mem_we_o    = MemWriteM_i & mem_req;
    assign mem_addr_o  = ALUResultM_i[ADDR_WIDTH-1:0];
    assign mem_wdata_o = WriteDataM_i;
    assign StallM_o    = stall;
    assign err_o       = err_q;

    mem_wb_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_WIDTH  (REG_WIDTH)
    ) u_mem_wb_reg (
        .clk          (clk),
        .rst          (rst),
        .load_i       (wb_load),
        .alu_result_i (ALUResultM_i),
        .write_reg_i  (WriteRegM_i),
        .reg_write_i  (RegWriteM_i),
        .mem_to_reg_i (is_load),
        .rdata_i      (mem_rdata_i),
        .wb_result_o  (WBResultW_o),
        .mem_data_o   (memData_r_o),
        .write_reg_o  (WriteRegW_o),
        .reg_write_o  (RegWriteW_o),
        .mem_to_reg_o (MemToRegW_o)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vectors, an age-based reference model checked
// every cycle, and literal expectations for the key scenarios.
module tb_mem_stage;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] aluResult = '0;
    logic [15:0] writeData = '0;
    logic [3:0]  writeReg = '0;
    logic        validM = 1'b0;
    logic        regWriteM = 1'b0;
    logic        memToRegM = 1'b0;
    logic        memWriteM = 1'b0;
    logic [15:0] memRdata = '0;
    logic        memReady = 1'b0;

    logic        memReq;
    logic        memWe;
    logic [7:0]  memAddr;
    logic [15:0] memWdata;
    logic [15:0] wbResult;
    logic [15:0] memData;
    logic [3:0]  writeRegW;
    logic        regWriteW;
    logic        memToRegW;
    logic        stallM;
    logic        errFlag;

    int compared = 0;
    int mismatched = 0;
    bit checking = 1'b0;

    mem_stage dut (
        .clk          (clk),
        .rst          (rst),
        .ALUResultM_i (aluResult),
        .WriteDataM_i (writeData),
        .WriteRegM_i  (writeReg),
        .ValidM_i     (validM),
        .RegWriteM_i  (regWriteM),
        .MemToRegM_i  (memToRegM),
        .MemWriteM_i  (memWriteM),
        .mem_req_o    (memReq),
        .mem_we_o     (memWe),
        .mem_addr_o   (memAddr),
        .mem_wdata_o  (memWdata),
        .mem_rdata_i  (memRdata),
        .mem_ready_i  (memReady),
        .WBResultW_o  (wbResult),
        .memData_r_o  (memData),
        .WriteRegW_o  (writeRegW),
        .RegWriteW_o  (regWriteW),
        .MemToRegW_o  (memToRegW),
        .StallM_o     (stallM),
        .err_o        (errFlag)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Reference model: "age" is how many cycles the current memory op has
    // already been presented; the request is live for ages 0..TIMEOUT and
    // age TIMEOUT+1 is the abort cycle.
    int          age = 0;
    logic [15:0] mWbResult = '0;
    logic [15:0] mMemData = '0;
    logic [3:0]  mWriteReg = '0;
    logic        mRegWrite = 1'b0;
    logic        mMemToReg = 1'b0;
    logic        mErr = 1'b0;

    logic memOp, expReq, expStall, expDone, abortNow, wbTake, loadOp;

    // Expected combinational behaviour for the current inputs
    always_comb begin
        memOp    = validM & (memToRegM | memWriteM);
        loadOp   = memToRegM & ~memWriteM;
        expReq   = rst & memOp & (age <= TIMEOUT);
        abortNow = rst & memOp & (age == TIMEOUT + 1);
        expDone  = expReq & memReady;
        expStall = expReq & ~memReady;
        wbTake   = rst & validM & ~expStall & (~memOp | expDone);
    end

    // Model state advance at each clock edge, cleared by reset
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            age       <= 0;
            mWbResult <= '0;
            mMemData  <= '0;
            mWriteReg <= '0;
            mRegWrite <= 1'b0;
            mMemToReg <= 1'b0;
            mErr      <= 1'b0;
        end else begin
            age <= expStall ? age + 1 : 0;
            if (abortNow) mErr <= 1'b1;
            if (wbTake) begin
                mWbResult <= aluResult;
                mWriteReg <= writeReg;
                mRegWrite <= regWriteM;
                mMemToReg <= loadOp;
                if (loadOp) mMemData <= memRdata;
            end else begin
                mRegWrite <= 1'b0;
                mMemToReg <= 1'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (checking) begin
            checkOutput("mdl_req",      32'(memReq),    32'(expReq));
            checkOutput("mdl_we",       32'(memWe),     32'(expReq & memWriteM));
            checkOutput("mdl_addr",     32'(memAddr),   32'(aluResult[7:0]));
            checkOutput("mdl_wdata",    32'(memWdata),  32'(writeData));
            checkOutput("mdl_stall",    32'(stallM),    32'(expStall));
            checkOutput("mdl_wbresult", 32'(wbResult),  32'(mWbResult));
            checkOutput("mdl_memdata",  32'(memData),   32'(mMemData));
            checkOutput("mdl_writereg", 32'(writeRegW), 32'(mWriteReg));
            checkOutput("mdl_regwrite", 32'(regWriteW), 32'(mRegWrite));
            checkOutput("mdl_memtoreg", 32'(memToRegW), 32'(mMemToReg));
            checkOutput("mdl_err",      32'(errFlag),   32'(mErr));
        end
    end

    task automatic applyStimulus(input logic v, input logic rw, input logic m2r, input logic mw,
                                 input logic [15:0] alu, input logic [15:0] wd, input logic [3:0] wr,
                                 input logic [15:0] rd, input logic rdy);
        @(posedge clk);
        #1;
        validM    = v;
        regWriteM = rw;
        memToRegM = m2r;
        memWriteM = mw;
        aluResult = alu;
        writeData = wd;
        writeReg  = wr;
        memRdata  = rd;
        memReady  = rdy;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0, 16'h0000, 1'b0);
    endtask

    initial begin
        int stallCycles;

        repeat (2) @(posedge clk);
        #3;
        // Reset state
        checkOutput("rst_req",      32'(memReq),    32'd0);
        checkOutput("rst_stall",    32'(stallM),    32'd0);
        checkOutput("rst_wbresult", 32'(wbResult),  32'd0);
        checkOutput("rst_regwrite", 32'(regWriteW), 32'd0);
        checkOutput("rst_err",      32'(errFlag),   32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        checking = 1'b1;

        // Zero-wait load
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0012, 16'h0000, 4'd3, 16'hA5A5, 1'b1);
        #2;
        checkOutput("zw_req",   32'(memReq),  32'd1);
        checkOutput("zw_addr",  32'(memAddr), 32'h12);
        checkOutput("zw_stall", 32'(stallM),  32'd0);
        applyIdle();
        #2;
        checkOutput("zw_memdata",  32'(memData),   32'hA5A5);
        checkOutput("zw_memtoreg", 32'(memToRegW), 32'd1);
        checkOutput("zw_regwrite", 32'(regWriteW), 32'd1);
        checkOutput("zw_writereg", 32'(writeRegW), 32'd3);

        // Plain ALU op
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'hBEEF, 16'h0000, 4'd5, 16'h1111, 1'b0);
        #2;
        checkOutput("alu_req", 32'(memReq), 32'd0);
        applyIdle();
        #2;
        checkOutput("alu_wbresult", 32'(wbResult),  32'hBEEF);
        checkOutput("alu_memtoreg", 32'(memToRegW), 32'd0);
        checkOutput("alu_memdata",  32'(memData),   32'hA5A5);

        // Store answered on the fourth request cycle: three stall cycles
        stallCycles = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'h0040, 16'hCAFE, 4'd0, 16'h0000, cyc == 3);
            #2;
            if (stallM) stallCycles++;
            checkOutput("st_we", 32'(memWe), 32'd1);
            if (cyc > 0) checkOutput("st_bubble", 32'(regWriteW), 32'd0);
        end
        applyIdle();
        #2;
        checkOutput("st_stallcycles", 32'(stallCycles), 32'd3);
        checkOutput("st_regwrite",    32'(regWriteW),    32'd0);
        checkOutput("st_wbresult",    32'(wbResult),     32'h0040);

        // Back-to-back zero-wait loads, upper address bits dropped
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'hAB34, 16'h0000, 4'd7, 16'h1234, 1'b1);
        #2;
        checkOutput("b2b_addr", 32'(memAddr), 32'h34);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0056, 16'h0000, 4'd8, 16'h5678, 1'b1);
        #2;
        checkOutput("b2b_req2",    32'(memReq),  32'd1);
        checkOutput("b2b_memdata", 32'(memData), 32'h1234);
        applyIdle();
        #2;
        checkOutput("b2b_memdata2", 32'(memData),   32'h5678);
        checkOutput("b2b_writereg", 32'(writeRegW), 32'd8);

        // Spurious ready with nothing valid
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0099, 16'h0000, 4'd9, 16'hDEAD, 1'b1);
        #2;
        checkOutput("spur_req", 32'(memReq), 32'd0);
        applyIdle();
        #2;
        checkOutput("spur_memdata",  32'(memData),   32'h5678);
        checkOutput("spur_writereg", 32'(writeRegW), 32'd8);
        checkOutput("spur_regwrite", 32'(regWriteW), 32'd0);

        // Load never answered: issue cycle plus 15 waiting cycles stall, then abort
        stallCycles = 0;
        for (int cyc = 0; cyc < TIMEOUT + 2; cyc++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0070, 16'h0000, 4'd4, 16'hFFFF, 1'b0);
            #2;
            if (stallM) stallCycles++;
        end
        checkOutput("to_stallcycles", 32'(stallCycles), 32'(TIMEOUT + 1));
        checkOutput("to_req_abort",   32'(memReq),      32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0101, 16'h0000, 4'd2, 16'h0000, 1'b0);
        #2;
        checkOutput("to_err",    32'(errFlag),   32'd1);
        checkOutput("to_bubble", 32'(regWriteW), 32'd0);
        checkOutput("to_stall",  32'(stallM),    32'd0);
        applyIdle();
        #2;
        checkOutput("to_next_wbresult", 32'(wbResult),  32'h0101);
        checkOutput("to_next_regwrite", 32'(regWriteW), 32'd1);
        checkOutput("to_err_sticky",    32'(errFlag),   32'd1);

        // Reset while waiting on memory
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000, 4'd6, 16'h0000, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000, 4'd6, 16'h0000, 1'b0);
        #2;
        checkOutput("rw_stall_before", 32'(stallM), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        checkOutput("rw_req",      32'(memReq),    32'd0);
        checkOutput("rw_stall",    32'(stallM),    32'd0);
        checkOutput("rw_wbresult", 32'(wbResult),  32'd0);
        checkOutput("rw_memdata",  32'(memData),   32'd0);
        checkOutput("rw_writereg", 32'(writeRegW), 32'd0);
        checkOutput("rw_err",      32'(errFlag),   32'd0);
        applyIdle();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        checkOutput("rw_idle_req", 32'(memReq), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0033, 16'h0000, 4'd1, 16'h0F0F, 1'b1);
        #2;
        checkOutput("rw_load_stall", 32'(stallM), 32'd0);
        applyIdle();
        #2;
        checkOutput("rw_load_memdata", 32'(memData), 32'h0F0F);

        applyIdle();
        @(posedge clk);
        #1;
        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH 16 (datapath width); ADDR_WIDTH 8 (data-memory address width); REG_WIDTH 4 (register index width); TIMEOUT 15 (max wait cycles per memory access).
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 ALUResultM_i  in  DATA_WIDTH  EX/MEM ALU result or effective address.
REQ-005 WriteDataM_i  in  DATA_WIDTH  EX/MEM store data.
REQ-006 WriteRegM_i  in  REG_WIDTH  EX/MEM destination register.
REQ-007 ValidM_i, RegWriteM_i, MemToRegM_i, MemWriteM_i  in  1 each  EX/MEM valid bit and controls.
REQ-008 mem_req_o, mem_we_o  out  1 each  data-memory request and write enable.
REQ-009 mem_addr_o  out  ADDR_WIDTH  data-memory address.
REQ-010 mem_wdata_o  out  DATA_WIDTH  data-memory write data.
REQ-011 mem_rdata_i  in  DATA_WIDTH  data-memory read data, valid only with mem_ready_i.
REQ-012 mem_ready_i  in  1  data-memory completion, one-cycle pulse.
REQ-013 WBResultW_o, memData_r_o  out  DATA_WIDTH each  MEM/WB ALU result and load data to WB.
REQ-014 WriteRegW_o  out  REG_WIDTH  MEM/WB destination register.
REQ-015 RegWriteW_o, MemToRegW_o  out  1 each  MEM/WB controls.
REQ-016 StallM_o  out  1  freeze request to the hazard unit (holds EX/MEM and earlier stages).
REQ-017 err_o  out  1  sticky memory-timeout flag.

Function
REQ-018 A memory op SHALL be ValidM_i & (MemToRegM_i | MemWriteM_i); MemToRegM_i & MemWriteM_i together SHALL be treated as a store.
REQ-019 The FSM SHALL have states IDLE and WAIT; IDLE->WAIT on a memory op without mem_ready_i; WAIT->IDLE on mem_ready_i or on timeout.
REQ-020 mem_req_o SHALL be high combinationally whenever a memory op is present in IDLE, or in WAIT (not timed out).
REQ-021 mem_we_o SHALL equal MemWriteM_i & mem_req_o; mem_addr_o = ALUResultM_i[ADDR_WIDTH-1:0] (upper bits ignored); mem_wdata_o = WriteDataM_i.
REQ-022 StallM_o SHALL equal mem_req_o & ~mem_ready_i; zero-wait memory (ready in same cycle as req) SHALL give no stall.
REQ-023 On the completion cycle (mem_req_o & mem_ready_i), and for every valid non-memory op, MEM/WB SHALL latch ALUResultM_i, WriteRegM_i, RegWriteM_i, MemToRegM_i, with memData_r_o <= mem_rdata_i for loads; latency 1 cycle.
REQ-024 While StallM_o is high, or ValidM_i is low, MEM/WB SHALL load a bubble: RegWriteW_o = 0, MemToRegW_o = 0; data fields may hold.
REQ-025 A wait counter SHALL clear on entering WAIT and increment each WAIT cycle; at count == TIMEOUT without ready, FSM SHALL return to IDLE, drop StallM_o, insert a bubble, and set err_o.
REQ-026 A mem_ready_i arriving with no outstanding request SHALL be ignored.
REQ-027 err_o SHALL remain set until reset.
REQ-028 Back-to-back memory ops SHALL each issue a new request; no cycle is inserted between completion and the next request.

Reset
REQ-029 On rst low, FSM SHALL go to IDLE, counter 0, err_o 0, and all MEM/WB outputs 0, immediately and asynchronously.
REQ-030 mem_req_o and StallM_o SHALL be 0 while rst is low; an access in flight SHALL be abandoned.

Structure
REQ-031 The state encoding, DATA/ADDR/REG widths and the TIMEOUT default SHALL reside in the shared pipeline package.
REQ-032 The MEM/WB register with bubble insert SHALL be a sub-module named mem_wb_reg; the FSM, counter and memory interface SHALL be in mem_stage.

Verification
REQ-033 Zero-wait load (ALUResultM_i=0x0012, WriteRegM_i=3, ready with req) -> StallM_o never high; next cycle memData_r_o = rdata, MemToRegW_o=1, RegWriteW_o=1, WriteRegW_o=3.
REQ-034 Store with ready after 3 cycles -> mem_we_o=1, StallM_o high for exactly 3 cycles, bubbles out during them, RegWriteW_o=0 after completion.
REQ-035 ALU op (ALUResultM_i=0xBEEF, RegWrite=1) -> mem_req_o=0; next cycle WBResultW_o=0xBEEF, MemToRegW_o=0.
REQ-036 Load, ready never returned -> stall for 15 WAIT cycles, then err_o=1, bubble, next op proceeds.
REQ-037 rst asserted in WAIT -> mem_req_o, StallM_o, all outputs 0 in the same cycle; after release, FSM is in IDLE.
REQ-038 Spurious mem_ready_i in IDLE with ValidM_i=0 -> no MEM/WB write, no state change.
